// File: rtl/message_printer.sv
// message_printer: command-driven UART hex formatter.
// Receives CMD_CHAR followed by a 32-bit little-endian operand, then prints the
// operand as 8 uppercase hex digits plus CR LF and shows its low byte on ledout.
// Optional macro PRINTER_ECHO_EN: echo every accepted rx byte before consuming the next.
module message_printer #(
  parameter logic [7:0]  CMD_CHAR   = 8'h68,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] ledout
);

  localparam int unsigned GAP_W = 4;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned NUM_CHARS = 10;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    PRINT,
    WAIT
`ifdef PRINTER_ECHO_EN
    ,
    ECHO,
    EWAIT
`endif
  } state_t;

  state_t             state, state_n;
  logic [1:0]         cnt, cnt_n;
  logic [31:0]        operand, operand_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [7:0]         tx_data_n;
  logic               new_tx_data_n;
  logic [7:0]         ledout_n;
  logic [3:0]         nib;
  logic [7:0]         cur_char;
`ifdef PRINTER_ECHO_EN
  state_t             ret_state, ret_state_n;
  logic [7:0]         echo_byte, echo_byte_n;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character for the current print index: 8 hex digits MSB first, then CR LF.
  always_comb begin
    nib = 4'(operand >> (5'd28 - {idx[2:0], 2'b00}));
    if (idx == IDX_W'(8))      cur_char = 8'h0D;
    else if (idx == IDX_W'(9)) cur_char = 8'h0A;
    else                       cur_char = hex_char(nib);
  end

  // State and output registers; synchronous reset abandons any frame or print.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      operand     <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      ledout      <= '0;
`ifdef PRINTER_ECHO_EN
      ret_state   <= IDLE;
      echo_byte   <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      operand     <= operand_n;
      idx         <= idx_n;
      gap_cnt     <= gap_cnt_n;
      tx_data     <= tx_data_n;
      new_tx_data <= new_tx_data_n;
      ledout      <= ledout_n;
`ifdef PRINTER_ECHO_EN
      ret_state   <= ret_state_n;
      echo_byte   <= echo_byte_n;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    operand_n     = operand;
    idx_n         = idx;
    gap_cnt_n     = gap_cnt;
    tx_data_n     = tx_data;
    new_tx_data_n = 1'b0;
    ledout_n      = ledout;
`ifdef PRINTER_ECHO_EN
    ret_state_n   = ret_state;
    echo_byte_n   = echo_byte;
`endif
    case (state)
      IDLE: begin
        if (new_rx_data && (rx_data == CMD_CHAR)) begin
          cnt_n   = '0;
          state_n = RECV;
`ifdef PRINTER_ECHO_EN
          echo_byte_n = rx_data;
          ret_state_n = RECV;
          state_n     = ECHO;
`endif
        end
      end
      RECV: begin
        if (new_rx_data) begin
          operand_n[{cnt, 3'b000} +: 8] = rx_data;
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) begin
            ledout_n = operand[7:0];
            idx_n    = '0;
            state_n  = PRINT;
          end
`ifdef PRINTER_ECHO_EN
          echo_byte_n = rx_data;
          ret_state_n = (cnt == 2'd3) ? PRINT : RECV;
          state_n     = ECHO;
`endif
        end
      end
      PRINT: begin
        if (!tx_busy) begin
          tx_data_n     = cur_char;
          new_tx_data_n = 1'b1;
          gap_cnt_n     = '0;
          state_n       = WAIT;
        end
      end
      WAIT: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          idx_n   = idx + IDX_W'(1);
          state_n = (idx == IDX_W'(NUM_CHARS - 1)) ? IDLE : PRINT;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
`ifdef PRINTER_ECHO_EN
      ECHO: begin
        if (!tx_busy) begin
          tx_data_n     = echo_byte;
          new_tx_data_n = 1'b1;
          gap_cnt_n     = '0;
          state_n       = EWAIT;
        end
      end
      EWAIT: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_n = ret_state;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_message_printer.sv
// Self-checking bench for message_printer (default build, echo disabled).
module tb_message_printer;

  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic [7:0] ledout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_viol = 0;
  logic [7:0] txq[$];
  int         txc[$];

  message_printer #(.CMD_CHAR(8'h68), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_busy(tx_busy), .rx_data(rx_data), .new_rx_data(new_rx_data), .ledout(ledout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every transmit strobe with its cycle number.
  always @(negedge clk) begin
    if (new_tx_data) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
      if (tx_busy) busy_viol <= busy_viol + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int when);
    new_rx_data = 1'b1;
    rx_data     = b;
    when        = cyc;
    tick(1);
    new_rx_data = 1'b0;
  endtask

  // gap < 0 selects a random idle gap (0..3 cycles) between strobes.
  task automatic send_frame(input logic [31:0] v, input int gap, output int last);
    int g;
    send_byte(8'h68, last);
    for (int i = 0; i < 4; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      tick(g);
      send_byte(v[8*i +: 8], last);
    end
  endtask

  function automatic int exp_char(input logic [31:0] v, input int k);
    int d;
    if (k == 8) return 'h0D;
    if (k == 9) return 'h0A;
    d = int'((v >> (28 - 4 * k)) & 32'hF);
    return (d < 10) ? ('h30 + d) : ('h41 + d - 10);
  endfunction

  task automatic expect_print(input logic [31:0] v, input int last, input bit lat);
    int w = 0;
    while (txq.size() < 10 && w < 400) begin
      tick(1);
      w++;
    end
    tick(2);
    chk("print_len", txq.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < txq.size()) chk($sformatf("char%0d", k), int'(txq[k]), exp_char(v, k));
    if (lat && txc.size() > 0) chk("first_latency", txc[0] - last, 2);
    for (int k = 1; k < 10; k++)
      if (k < txc.size()) chk($sformatf("spacing%0d", k), txc[k] - txc[k-1], GAP + 1);
    chk("ledout", int'(ledout), int'(v[7:0]));
    txq.delete();
    txc.delete();
  endtask

  initial begin
    int last;
    int w;
    int dummy;
    logic [31:0] v;
    logic [7:0] g;

    // reset state
    tick(3);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_new_tx", int'(new_tx_data), 0);
    chk("rst_ledout", int'(ledout), 0);
    rst = 1'b0;
    tick(2);

    // basic frame, repeated
    send_frame(32'h0000_08B1, 1, last);
    expect_print(32'h0000_08B1, last, 1'b1);
    send_frame(32'h0000_08B1, 1, last);
    expect_print(32'h0000_08B1, last, 1'b1);

    // non-command bytes in IDLE are ignored
    send_byte(8'h41, dummy);
    tick(1);
    send_byte(8'h00, dummy);
    tick(4);
    chk("idle_ignored_tx", txq.size(), 0);
    chk("idle_ignored_led", int'(ledout), 'hB1);
    send_frame(32'hDEAD_BEEF, 1, last);
    expect_print(32'hDEAD_BEEF, last, 1'b1);

    // transmitter busy at first character
    tx_busy = 1'b1;
    send_frame(32'h0000_08B1, 1, last);
    tick(20);
    chk("busy_no_strobe", txq.size(), 0);
    tx_busy = 1'b0;
    expect_print(32'h0000_08B1, last, 1'b0);

    // reset after three printed characters
    v = $urandom();
    send_frame(v, 1, last);
    w = 0;
    while (txq.size() < 3 && w < 100) begin
      tick(1);
      w++;
    end
    chk("pre_reset_chars", txq.size(), 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_tx_data", int'(tx_data), 0);
    chk("mid_rst_new_tx", int'(new_tx_data), 0);
    chk("mid_rst_ledout", int'(ledout), 0);
    txq.delete();
    txc.delete();
    tick(30);
    chk("post_reset_silent", txq.size(), 0);
    v = $urandom();
    send_frame(v, 1, last);
    expect_print(v, last, 1'b1);

    // extra bytes during print are dropped
    v = $urandom();
    send_frame(v, 1, last);
    w = 0;
    while (txq.size() < 1 && w < 100) begin
      tick(1);
      w++;
    end
    send_byte(8'h68, dummy);
    send_byte(8'($urandom()), dummy);
    tick(1);
    send_byte(8'($urandom()), dummy);
    expect_print(v, last, 1'b1);
    tick(30);
    chk("drop_no_extra", txq.size(), 0);

    // randomized frames with random garbage and spacing
    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom());
        if (g == 8'h68) g = 8'h69;
        send_byte(g, dummy);
        tick(int'($urandom_range(0, 2)));
      end
      v = $urandom();
      send_frame(v, -1, last);
      expect_print(v, last, 1'b1);
    end

    chk("busy_violations", busy_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
